// File: rtl/keypad_adder_pkg.sv
// Shared types and helpers for the keypad-driven decimal adder:
// key codes, FSM states, keypad decode and 7-segment lookup.
package keypad_adder_pkg;

    typedef enum logic [4:0] {
        K0    = 5'd0,
        K1    = 5'd1,
        K2    = 5'd2,
        K3    = 5'd3,
        K4    = 5'd4,
        K5    = 5'd5,
        K6    = 5'd6,
        K7    = 5'd7,
        K8    = 5'd8,
        K9    = 5'd9,
        KA    = 5'd10,
        KB    = 5'd11,
        KC    = 5'd12,
        KD    = 5'd13,
        KSTAR = 5'd14,
        KHASH = 5'd15,
        KNONE = 5'd16
    } key_t;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        SHOW_SUM = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // True when exactly one line of an active-low group is pulled low.
    function automatic logic one_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Index of the single low line (only meaningful when one_low is true).
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Keypad matrix decode; multiple or missing lines give KNONE.
    function automatic key_t decode_key(input logic [3:0] row, input logic [3:0] col);
        key_t k;
        k = KNONE;
        if (one_low(row) && one_low(col)) begin
            case ({low_idx(row), low_idx(col)})
                4'h0:    k = K1;
                4'h1:    k = K2;
                4'h2:    k = K3;
                4'h3:    k = KA;
                4'h4:    k = K4;
                4'h5:    k = K5;
                4'h6:    k = K6;
                4'h7:    k = KB;
                4'h8:    k = K7;
                4'h9:    k = K8;
                4'hA:    k = K9;
                4'hB:    k = KC;
                4'hC:    k = KSTAR;
                4'hD:    k = K0;
                4'hE:    k = KHASH;
                4'hF:    k = KD;
                default: k = KNONE;
            endcase
        end else begin
            k = KNONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_adder_top_key_debouncer.sv
// Keypad front end: synchronizes the matrix lines, requires a stable
// window before accepting a new state, and emits one pulse per press.
module key_debouncer
    import keypad_adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [3:0] column,
    output logic       key_event,
    output key_t       key_code
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    sync1_r;
    logic [7:0]    sync2_r;
    logic [7:0]    cand_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    deb_r;
    logic          armed_r;
    logic          prev_valid_r;
    logic          key_event_r;
    key_t          key_code_r;
    key_t          cand_key_s;
    key_t          deb_key_s;
    logic          deb_valid_s;

    assign cand_key_s  = decode_key(cand_r[7:4], cand_r[3:0]);
    assign deb_key_s   = decode_key(deb_r[7:4], deb_r[3:0]);
    assign deb_valid_s = (deb_key_s != KNONE);

    // Two-flop synchronizer on the raw {row,column} lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 8'hFF;
            sync2_r <= 8'hFF;
        end else begin
            sync1_r <= {row, column};
            sync2_r <= sync1_r;
        end
    end

    // Stability window; armed only after a real debounced release so a key
    // held across reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r  <= 8'hFF;
            cnt_r   <= '0;
            deb_r   <= 8'hFF;
            armed_r <= 1'b0;
        end else if (sync2_r != cand_r) begin
            cand_r <= sync2_r;
            cnt_r  <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            deb_r <= cand_r;
            if (cand_key_s == KNONE) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // One-cycle event on the no-key to valid-key transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_r <= 1'b0;
            key_event_r  <= 1'b0;
            key_code_r   <= KNONE;
        end else begin
            prev_valid_r <= deb_valid_s;
            key_event_r  <= armed_r & deb_valid_s & ~prev_valid_r;
            key_code_r   <= deb_key_s;
        end
    end

    assign key_event = key_event_r;
    assign key_code  = key_code_r;

endmodule

// File: rtl/keypad_adder_top.sv
// Keypad-driven 3-digit decimal adder: operand entry FSM, binary to BCD
// conversion and a 4-digit multiplexed active-low 7-segment display.
module keypad_adder_top
    import keypad_adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column,
    input  logic [3:0] row,
    output logic [6:0] seg,
    output logic [3:0] transis
);

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

    logic        key_evt_s;
    key_t        key_code_s;
    state_t      state_r, state_n;
    logic [9:0]  a_r, a_n, b_r, b_n;
    logic [1:0]  a_cnt_r, a_cnt_n, b_cnt_r, b_cnt_n;
    logic [10:0] sum_r, sum_n;
    logic [10:0] sum_mod_s;
    logic [3:0]  digit_s;
    logic [10:0] disp_val_s;
    logic [15:0] bcd_s;
    logic [RW-1:0] ref_cnt_r;
    logic [1:0]  sel_r;
    logic [3:0]  cur_digit_s;
    logic [6:0]  seg_r;
    logic [3:0]  transis_r;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .column    (column),
        .key_event (key_evt_s),
        .key_code  (key_code_s)
    );

    assign digit_s   = key_code_s[3:0];
    assign sum_mod_s = (sum_r >= 11'd1000) ? (sum_r - 11'd1000) : sum_r;

    // FSM and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ENTER_A;
            a_r     <= 10'd0;
            b_r     <= 10'd0;
            a_cnt_r <= 2'd0;
            b_cnt_r <= 2'd0;
            sum_r   <= 11'd0;
        end else begin
            state_r <= state_n;
            a_r     <= a_n;
            b_r     <= b_n;
            a_cnt_r <= a_cnt_n;
            b_cnt_r <= b_cnt_n;
            sum_r   <= sum_n;
        end
    end

    // Next-state and operand update on each key event.
    always_comb begin
        state_n = state_r;
        a_n     = a_r;
        b_n     = b_r;
        a_cnt_n = a_cnt_r;
        b_cnt_n = b_cnt_r;
        sum_n   = sum_r;
        if (key_evt_s) begin
            if (key_code_s <= K9) begin
                case (state_r)
                    ENTER_A: begin
                        if (a_cnt_r < 2'd3) begin
                            a_n     = a_r * 10'd10 + {6'd0, digit_s};
                            a_cnt_n = a_cnt_r + 2'd1;
                        end else begin
                            a_n = a_r;
                        end
                    end
                    ENTER_B: begin
                        if (b_cnt_r < 2'd3) begin
                            b_n     = b_r * 10'd10 + {6'd0, digit_s};
                            b_cnt_n = b_cnt_r + 2'd1;
                        end else begin
                            b_n = b_r;
                        end
                    end
                    SHOW_SUM: begin
                        a_n     = {6'd0, digit_s};
                        a_cnt_n = 2'd1;
                        b_n     = 10'd0;
                        b_cnt_n = 2'd0;
                        state_n = ENTER_A;
                    end
                    default: state_n = ENTER_A;
                endcase
            end else begin
                case (key_code_s)
                    KA: begin
                        if (state_r == ENTER_A) begin
                            b_n     = 10'd0;
                            b_cnt_n = 2'd0;
                            state_n = ENTER_B;
                        end else if (state_r == SHOW_SUM) begin
                            a_n     = sum_mod_s[9:0];
                            a_cnt_n = 2'd3;
                            b_n     = 10'd0;
                            b_cnt_n = 2'd0;
                            state_n = ENTER_B;
                        end else begin
                            state_n = state_r;
                        end
                    end
                    KB: begin
                        if (state_r == ENTER_B) begin
                            sum_n   = {1'b0, a_r} + {1'b0, b_r};
                            state_n = SHOW_SUM;
                        end else begin
                            state_n = state_r;
                        end
                    end
                    KC: begin
                        state_n = ENTER_A;
                        a_n     = 10'd0;
                        b_n     = 10'd0;
                        a_cnt_n = 2'd0;
                        b_cnt_n = 2'd0;
                        sum_n   = 11'd0;
                    end
                    default: state_n = state_r;
                endcase
            end
        end else begin
            state_n = state_r;
        end
    end

    // Value shown for the current state.
    always_comb begin
        case (state_r)
            ENTER_A:  disp_val_s = {1'b0, a_r};
            ENTER_B:  disp_val_s = {1'b0, b_r};
            SHOW_SUM: disp_val_s = sum_r;
            default:  disp_val_s = 11'd0;
        endcase
    end

    // Double-dabble: 11-bit binary to four BCD digits.
    always_comb begin
        bcd_s = 16'd0;
        for (int i = 10; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                bcd_s[d*4 +: 4] = (bcd_s[d*4 +: 4] >= 4'd5) ? (bcd_s[d*4 +: 4] + 4'd3)
                                                             : bcd_s[d*4 +: 4];
            end
            bcd_s = {bcd_s[14:0], disp_val_s[i]};
        end
    end

    // BCD nibble for the digit currently being driven.
    always_comb begin
        case (sel_r)
            2'd0:    cur_digit_s = bcd_s[3:0];
            2'd1:    cur_digit_s = bcd_s[7:4];
            2'd2:    cur_digit_s = bcd_s[11:8];
            2'd3:    cur_digit_s = bcd_s[15:12];
            default: cur_digit_s = 4'd0;
        endcase
    end

    // Refresh counter and digit select rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_r <= '0;
            sel_r     <= 2'd0;
        end else if (ref_cnt_r == REF_MAX) begin
            ref_cnt_r <= '0;
            sel_r     <= sel_r + 2'd1;
        end else begin
            ref_cnt_r <= ref_cnt_r + RW'(1);
        end
    end

    // Registered display outputs; seg and transis come from the same select.
    always_ff @(posedge clk) begin
        if (rst) begin
            transis_r <= 4'b1110;
            seg_r     <= 7'b1000000;
        end else begin
            transis_r <= ~(4'b0001 << sel_r);
            seg_r     <= seg7(cur_digit_s);
        end
    end

    assign seg     = seg_r;
    assign transis = transis_r;

endmodule

// File: tb/tb_keypad_adder_top.sv
// Directed self-checking bench for keypad_adder_top.
module tb_keypad_adder_top;
    import keypad_adder_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] column;
    logic [3:0] row;
    logic [6:0] seg;
    logic [3:0] transis;

    int total = 0;
    int bad   = 0;
    int evt_cnt = 0;

    keypad_adder_top #(.DEBOUNCE_CYCLES(16), .REFRESH_CYCLES(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .column  (column),
        .row     (row),
        .seg     (seg),
        .transis (transis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key event counter for press/no-press expectations.
    always @(posedge clk) begin
        if (dut.key_evt_s === 1'b1) evt_cnt <= evt_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic press(input int r, input int c, input int hold);
        row    = ~(4'b0001 << r);
        column = ~(4'b0001 << c);
        repeat (hold) @(posedge clk);
        row    = 4'hF;
        column = 4'hF;
        repeat (100) @(posedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
    endtask

    // Capture one full display rotation and compare to a 4-digit value.
    task automatic check_disp(input string tag, input int value);
        logic [6:0] got [4];
        int         v;
        logic       onehot_ok;
        for (int i = 0; i < 4; i++) got[i] = 7'b1111111;
        onehot_ok = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            case (transis)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: onehot_ok = 1'b0;
            endcase
        end
        chk({tag, "_onehot"}, {31'd0, onehot_ok}, 32'd1);
        v = value;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_d%0d", tag, i), {25'd0, got[i]}, {25'd0, exp_seg(v % 10)});
            v = v / 10;
        end
    endtask

    // Rotation order and per-digit dwell after reset release.
    task automatic check_rotation();
        logic [3:0] exp_seq [4];
        logic [3:0] prev;
        int         n;
        int         dwell;
        exp_seq[0] = 4'b1101;
        exp_seq[1] = 4'b1011;
        exp_seq[2] = 4'b0111;
        exp_seq[3] = 4'b1110;
        n = 0;
        dwell = 0;
        @(negedge clk);
        prev = transis;
        for (int t = 0; t < 200 && n < 4; t++) begin
            @(negedge clk);
            dwell++;
            if (transis !== prev) begin
                chk($sformatf("rot_step%0d", n), {28'd0, transis}, {28'd0, exp_seq[n]});
                if (n > 0) chk($sformatf("rot_dwell%0d", n), dwell, 16);
                n++;
                dwell = 0;
                prev = transis;
            end
        end
        chk("rot_count", n, 4);
    endtask

    task automatic seq55(input string tag);
        press(0, 0, 200);
        press(0, 0, 200);
        press(0, 3, 100);
        press(1, 0, 100);
        press(1, 0, 100);
        press(1, 3, 100);
        check_disp(tag, 55);
    endtask

    int base;

    initial begin
        rst    = 1'b1;
        row    = 4'hF;
        column = 4'hF;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("rst_transis", {28'd0, transis}, 32'b1110);
        chk("rst_seg", {25'd0, seg}, 32'b1000000);
        @(posedge clk);
        rst = 1'b0;
        check_rotation();
        check_disp("idle", 0);

        seq55("run1");
        pulse_rst();
        check_disp("after_rst", 0);
        seq55("run2");

        // Long hold gives a single event.
        pulse_rst();
        base = evt_cnt;
        press(1, 1, 1000);
        chk("hold_events", evt_cnt - base, 1);
        check_disp("hold5", 5);

        // Short glitch and two keys in one row are ignored.
        base = evt_cnt;
        press(2, 0, 8);
        chk("glitch_events", evt_cnt - base, 0);
        row    = 4'b1110;
        column = 4'b1100;
        repeat (100) @(posedge clk);
        row    = 4'hF;
        column = 4'hF;
        repeat (100) @(posedge clk);
        chk("dual_events", evt_cnt - base, 0);
        check_disp("glitch", 5);

        // Key held across reset must not register.
        row    = 4'b1110;
        column = 4'b1101;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        base = evt_cnt;
        repeat (200) @(posedge clk);
        row    = 4'hF;
        column = 4'hF;
        repeat (100) @(posedge clk);
        chk("midrst_events", evt_cnt - base, 0);
        check_disp("midrst", 0);
        press(0, 1, 100);
        check_disp("repress2", 2);

        // Clear, then max operands and overflowing digit.
        press(2, 3, 100);
        check_disp("clear1", 0);
        for (int i = 0; i < 4; i++) press(2, 2, 100);
        check_disp("a999", 999);
        press(0, 3, 100);
        for (int i = 0; i < 3; i++) press(2, 2, 100);
        press(1, 3, 100);
        check_disp("sum1998", 1998);
        press(2, 3, 100);
        check_disp("clear2", 0);
        chk("clear_state", {30'd0, dut.state_r}, {30'd0, ENTER_A});
        press(0, 2, 100);
        check_disp("after_clear3", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
